// File: rtl/ila_pkg.sv
// +----------------------------------------------------------------------------+
// | ila_pkg : shared ILA types and address-width helper                         |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

package ila_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2
   } ila_state_t;

   // Writer and reader both size their address buses through this.
   function automatic int ila_addr_w(input int depth);
      return (depth < 2) ? 1 : $clog2(depth);
   endfunction

endpackage

`default_nettype wire

// File: rtl/ila_ram_reader_if.sv
// +----------------------------------------------------------------------------+
// | ila_ram_reader_if : RAM read port plus AXI-Stream output of the ILA reader  |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

interface ila_ram_reader_if
   import ila_pkg::*;
#(
   parameter int RAM_WIDTH = 64,
   parameter int RAM_DEPTH = 512
);
   localparam int ADDR_W = ila_addr_w(RAM_DEPTH);

   logic [ADDR_W-1:0]    ram_addr;
   logic                 ram_we;
   logic [RAM_WIDTH-1:0] ram_dout;
   logic [RAM_WIDTH-1:0] m_tdata;
   logic                 m_tvalid;
   logic                 m_tready;
   logic                 m_tlast;

   modport master (
      output ram_addr,
      output ram_we,
      input  ram_dout,
      output m_tdata,
      output m_tvalid,
      output m_tlast,
      input  m_tready
   );

   modport slave (
      input  ram_addr,
      input  ram_we,
      output ram_dout,
      input  m_tdata,
      input  m_tvalid,
      input  m_tlast,
      output m_tready
   );

endinterface

`default_nettype wire

// File: rtl/ila_skid_fifo.sv
// +----------------------------------------------------------------------------+
// | ila_skid_fifo : 2-entry FIFO with registered head, absorbs RAM read latency |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module ila_skid_fifo #(
   parameter int WIDTH = 64
) (
   input  wire logic             clk,
   input  wire logic             rst_n,
   input  wire logic             push,
   input  wire logic [WIDTH-1:0] din,
   input  wire logic             pop,
   output logic      [WIDTH-1:0] dout,
   output logic                  valid,
   output logic      [1:0]       count
);

   logic [WIDTH-1:0] r_head;
   logic [WIDTH-1:0] r_tail;
   logic [1:0]       r_count;
   logic             w_pop;
   logic             w_push;

   assign w_pop  = pop && (r_count != 2'd0);
   assign w_push = push && ((r_count != 2'd2) || w_pop);

   // r_head is always the oldest entry, so the output never passes through a mux.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= 2'd0;
      end else begin
         case ({w_push, w_pop})
            2'b10: begin
               if (r_count == 2'd0) r_head <= din;
               else                 r_tail <= din;
               r_count <= r_count + 2'd1;
            end
            2'b01: begin
               r_head  <= r_tail;
               r_count <= r_count - 2'd1;
            end
            2'b11: begin
               if (r_count == 2'd1) begin
                  r_head <= din;
               end else begin
                  r_head <= r_tail;
                  r_tail <= din;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign dout  = r_head;
   assign valid = (r_count != 2'd0);
   assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/ila_ram_reader.sv
// +----------------------------------------------------------------------------+
// | ila_ram_reader : streams N samples from the circular ILA RAM as AXI-Stream  |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module ila_ram_reader
   import ila_pkg::*;
#(
   parameter int RAM_WIDTH = 64,
   parameter int RAM_DEPTH = 512
) (
   input  wire logic                              clk,
   input  wire logic                              rst_n,
   input  wire logic                              start,
   input  wire logic [ila_addr_w(RAM_DEPTH)-1:0]  start_addr,
   input  wire logic [ila_addr_w(RAM_DEPTH):0]    num_samples,
   output logic                                   busy,
   output logic                                   done,
   ila_ram_reader_if.master                       bus
);

   localparam int ADDR_W = ila_addr_w(RAM_DEPTH);
   localparam int CNT_W  = ADDR_W + 1;
   localparam logic [CNT_W-1:0]  c_depth     = CNT_W'(RAM_DEPTH);
   localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(RAM_DEPTH - 1);

   ila_state_t       r_state;
   ila_state_t       w_state_next;
   logic [CNT_W-1:0] r_n;
   logic [CNT_W-1:0] r_issued;
   logic [CNT_W-1:0] r_beats;
   logic [ADDR_W-1:0] r_addr;
   logic             r_inflight;
   logic             r_done;

   logic             w_issue;
   logic             w_load;
   logic             w_finish;
   logic             w_pop;
   logic             w_drained;
   logic             w_last_beat;
   logic [CNT_W-1:0] w_n_clamped;
   logic [2:0]       w_occupancy;
   logic [1:0]       w_fifo_count;
   logic             w_fifo_valid;
   logic [RAM_WIDTH-1:0] w_fifo_dout;

   assign w_n_clamped = (num_samples > c_depth) ? c_depth : num_samples;
   assign w_pop       = w_fifo_valid && bus.m_tready;
   // Entries the FIFO will hold after this cycle, counting the read already in flight.
   assign w_occupancy = {1'b0, w_fifo_count} + {2'b00, r_inflight} - {2'b00, w_pop};
   assign w_drained   = (w_occupancy == 3'd0);
   assign w_last_beat = ((r_beats + CNT_W'(1)) == r_n);

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      w_issue      = 1'b0;
      w_load       = 1'b0;
      w_finish     = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               if (w_n_clamped != '0) begin
                  w_load       = 1'b1;
                  w_state_next = READ;
               end else begin
                  w_finish = 1'b1;
               end
            end
         end
         READ: begin
            if (r_issued != r_n) w_issue = (w_occupancy < 3'd2);
            else                 w_state_next = DRAIN;
         end
         DRAIN: begin
            if (w_drained) begin
               w_finish     = 1'b1;
               w_state_next = IDLE;
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_n        <= '0;
         r_issued   <= '0;
         r_beats    <= '0;
         r_addr     <= '0;
         r_inflight <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_done     <= w_finish;
         r_inflight <= w_issue;
         if (w_load) begin
            r_n      <= w_n_clamped;
            r_addr   <= start_addr;
            r_issued <= '0;
            r_beats  <= '0;
         end else begin
            if (w_issue) begin
               r_issued <= r_issued + CNT_W'(1);
               r_addr   <= (r_addr == c_last_addr) ? '0 : r_addr + ADDR_W'(1);
            end
            if (w_pop) r_beats <= r_beats + CNT_W'(1);
         end
      end
   end

   ila_skid_fifo #(
      .WIDTH (RAM_WIDTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (r_inflight),
      .din   (bus.ram_dout),
      .pop   (w_pop),
      .dout  (w_fifo_dout),
      .valid (w_fifo_valid),
      .count (w_fifo_count)
   );

   assign busy         = (r_state != IDLE);
   assign done         = r_done;
   assign bus.ram_addr = r_addr;
   assign bus.ram_we   = 1'b0;
   assign bus.m_tdata  = w_fifo_dout;
   assign bus.m_tvalid = w_fifo_valid;
   assign bus.m_tlast  = w_fifo_valid && w_last_beat;

endmodule

`default_nettype wire

// File: tb/tb_ila_ram_reader.sv
// +----------------------------------------------------------------------------+
// | tb_ila_ram_reader : scoreboard bench for the ILA RAM reader                 |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_ila_ram_reader;
   import ila_pkg::*;

   localparam int W     = 64;
   localparam int DEPTH = 512;
   localparam int AW    = ila_addr_w(DEPTH);

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [AW-1:0] start_addr = '0;
   logic [AW:0]   num_samples = '0;
   logic          busy;
   logic          done;

   ila_ram_reader_if #(.RAM_WIDTH(W), .RAM_DEPTH(DEPTH)) bus ();

   ila_ram_reader #(.RAM_WIDTH(W), .RAM_DEPTH(DEPTH)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .start_addr  (start_addr),
      .num_samples (num_samples),
      .busy        (busy),
      .done        (done),
      .bus         (bus)
   );

   always #5 clk = ~clk;

   logic [W-1:0] mem [DEPTH];
   initial for (int i = 0; i < DEPTH; i++) mem[i] = W'(i) + 64'h100;
   always @(posedge clk) bus.ram_dout <= mem[bus.ram_addr];

   int ready_mode = 0;
   always begin
      @(posedge clk);
      #1;
      bus.m_tready = (ready_mode == 0) ? 1'b1 : 1'($urandom & 1);
   end

   typedef struct packed {
      logic [W-1:0] data;
      logic         last;
   } beat_t;

   beat_t exp_q [$];
   beat_t mon_e;
   int checks = 0;
   int errors = 0;
   int beats_seen = 0;
   int done_cnt = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] sample_at(input int a);
      return W'((a % DEPTH) + 'h100);
   endfunction

   // Monitor: scoreboard pop on each handshake, AXIS hold rule, done pulse width.
   logic         prev_stall = 1'b0;
   logic [W-1:0] prev_data = '0;
   logic         prev_last = 1'b0;
   logic         prev_done = 1'b0;
   always begin
      @(negedge clk);
      if (!rst_n) begin
         prev_stall = 1'b0;
         prev_done  = 1'b0;
      end else begin
         if (prev_stall) begin
            chk("hold_valid", 64'(bus.m_tvalid), 64'd1);
            chk("hold_data", bus.m_tdata, prev_data);
            chk("hold_last", 64'(bus.m_tlast), 64'(prev_last));
         end
         if (bus.m_tvalid && bus.m_tready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL extra_beat actual=%0h expected=none", bus.m_tdata);
            end else begin
               mon_e = exp_q.pop_front();
               chk("beat_data", bus.m_tdata, mon_e.data);
               chk("beat_last", 64'(bus.m_tlast), 64'(mon_e.last));
            end
            beats_seen++;
         end
         if (done) begin
            done_cnt++;
            if (prev_done) begin
               checks++;
               errors++;
               $display("FAIL done_width actual=2+ cycles expected=1");
            end
         end
         prev_done  = done;
         prev_stall = bus.m_tvalid && !bus.m_tready;
         prev_data  = bus.m_tdata;
         prev_last  = bus.m_tlast;
      end
   end

   task automatic do_start(input int addr, input int n, input bit model);
      int nc;
      @(posedge clk);
      #1;
      start       = 1'b1;
      start_addr  = AW'(addr);
      num_samples = (AW+1)'(n);
      if (model) begin
         nc = (n > DEPTH) ? DEPTH : n;
         for (int k = 0; k < nc; k++)
            exp_q.push_back(beat_t'{data: sample_at(addr + k), last: (k == nc - 1)});
      end
      @(posedge clk);
      #1;
      start       = 1'b0;
      start_addr  = AW'($urandom);
      num_samples = (AW+1)'($urandom);
   endtask

   task automatic wait_done(input int limit);
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < limit; k++) begin
         @(negedge clk);
         if (done) begin
            seen = 1'b1;
            break;
         end
      end
      chk("done_seen", 64'(seen), 64'd1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int a;
      int n;
      int d0;
      bit got3;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_tvalid", 64'(bus.m_tvalid), 64'd0);
      chk("rst_tlast", 64'(bus.m_tlast), 64'd0);
      chk("rst_addr", 64'(bus.ram_addr), 64'd0);
      chk("ram_we", 64'(bus.ram_we), 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);

      // Exact latency and full throughput.
      beats_seen = 0;
      do_start(0, 8, 1);
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         chk("t1_tvalid", 64'(bus.m_tvalid), 64'((c >= 3) && (c <= 10)));
         chk("t1_busy", 64'(busy), 64'((c >= 1) && (c <= 10)));
         chk("t1_done", 64'(done), 64'(c == 11));
      end
      chk("t1_beats", 64'(beats_seen), 64'd8);
      chk("t1_queue_empty", 64'(exp_q.size()), 64'd0);

      // Wrap around the end of the RAM.
      beats_seen = 0;
      do_start(510, 4, 1);
      wait_done(200);
      chk("t2_beats", 64'(beats_seen), 64'd4);
      chk("t2_queue_empty", 64'(exp_q.size()), 64'd0);

      // Random backpressure, then random transactions.
      ready_mode = 1;
      for (int t = 0; t < 4; t++) begin
         a = $urandom_range(0, DEPTH - 1);
         n = (t == 0) ? 16 : $urandom_range(1, 40);
         beats_seen = 0;
         do_start(a, n, 1);
         wait_done(2000);
         chk("t3_beats", 64'(beats_seen), 64'(n));
         chk("t3_queue_empty", 64'(exp_q.size()), 64'd0);
      end
      ready_mode = 0;

      // Zero-length readout.
      beats_seen = 0;
      do_start(7, 0, 1);
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         chk("t4_tvalid", 64'(bus.m_tvalid), 64'd0);
         chk("t4_busy", 64'(busy), 64'd0);
         chk("t4_done", 64'(done), 64'(c == 1));
      end

      // Oversized request clamps to the full RAM.
      beats_seen = 0;
      do_start($urandom_range(0, DEPTH - 1), 600, 1);
      wait_done(3000);
      chk("t4_clamp_beats", 64'(beats_seen), 64'd512);
      chk("t4_queue_empty", 64'(exp_q.size()), 64'd0);

      // Second start while busy is ignored.
      beats_seen = 0;
      do_start(100, 12, 1);
      @(posedge clk);
      #1;
      start       = 1'b1;
      start_addr  = AW'(300);
      num_samples = (AW+1)'(5);
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(300);
      chk("t5_beats", 64'(beats_seen), 64'd12);
      chk("t5_queue_empty", 64'(exp_q.size()), 64'd0);
      repeat (10) @(negedge clk);
      chk("t5_idle_busy", 64'(busy), 64'd0);
      chk("t5_no_extra", 64'(beats_seen), 64'd12);

      // Reset in the middle of a readout.
      beats_seen = 0;
      do_start(20, 10, 1);
      got3 = 1'b0;
      for (int k = 0; k < 100; k++) begin
         @(posedge clk);
         #1;
         if (beats_seen >= 3) begin
            got3 = 1'b1;
            break;
         end
      end
      chk("t6_three_beats", 64'(got3), 64'd1);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      exp_q.delete();
      d0 = done_cnt;
      @(negedge clk);
      chk("t6_tvalid", 64'(bus.m_tvalid), 64'd0);
      chk("t6_busy", 64'(busy), 64'd0);
      repeat (20) @(negedge clk);
      chk("t6_no_done", 64'(done_cnt), 64'(d0));
      chk("t6_no_beats", 64'(beats_seen), 64'd3);
      beats_seen = 0;
      a = $urandom_range(0, DEPTH - 1);
      do_start(a, 5, 1);
      wait_done(200);
      chk("t6_restart_beats", 64'(beats_seen), 64'd5);
      chk("t6_queue_empty", 64'(exp_q.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1);
   end

endmodule

`default_nettype wire
